// File: rtl/udp_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udp_tx_pkg: shared types and helpers for the UDP transmit packetizer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package udp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DROP    = 3'd2,
    HDR     = 3'd3,
    PAYLOAD = 3'd4
  } tx_state_t;

  localparam int UDP_HDR_LEN = 8;
  localparam int KEEP_MAX    = 16;

  // Keep is zero-extended by the caller up to the widest supported word.
  function automatic logic [4:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + {4'd0, keep[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_mux_packetizer_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter: round-robin grant starting after the pointer             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int CH = 2,
  parameter int IW = 1
) (
  input  logic [CH-1:0] i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [CH-1:0] o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int   c;
    logic found;
    c       = 0;
    found   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int off = 1; off <= CH; off++) begin
      c = (int'(i_ptr) + off) % CH;
      if (!found && i_req[c]) begin
        found      = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = IW'(c);
      end
    end
    o_any = found;
  end

endmodule
`default_nettype wire

// File: rtl/udp_tx_mux_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | udp_tx_mux_packetizer: round-robin AXIS frame buffer to UDP tx core  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module udp_tx_mux_packetizer
  import udp_tx_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int CH          = 2,
  parameter int DEPTH_WORDS = 256,
  parameter int TTL         = 64
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [CH*DATA_W-1:0]   s_tdata,
  input  logic [CH*DATA_W/8-1:0] s_tkeep,
  input  logic [CH-1:0]          s_tvalid,
  input  logic [CH-1:0]          s_tlast,
  output logic [CH-1:0]          s_tready,
  input  logic [31:0]            local_ip,
  input  logic [31:0]            dest_ip,
  input  logic [15:0]            local_port,
  input  logic [CH*16-1:0]       dest_ports,
  output logic                   tx_udp_hdr_valid,
  input  logic                   tx_udp_hdr_ready,
  output logic [5:0]             tx_udp_ip_dscp,
  output logic [1:0]             tx_udp_ip_ecn,
  output logic [7:0]             tx_udp_ip_ttl,
  output logic [31:0]            tx_udp_ip_source_ip,
  output logic [31:0]            tx_udp_ip_dest_ip,
  output logic [15:0]            tx_udp_source_port,
  output logic [15:0]            tx_udp_dest_port,
  output logic [15:0]            tx_udp_length,
  output logic [15:0]            tx_udp_checksum,
  output logic [7:0]             tx_udp_payload_axis_tdata,
  output logic                   tx_udp_payload_axis_tvalid,
  input  logic                   tx_udp_payload_axis_tready,
  output logic                   tx_udp_payload_axis_tlast,
  output logic                   tx_udp_payload_axis_tuser,
  output logic [15:0]            tx_frame_count,
  output logic [15:0]            drop_count,
  output logic [$clog2(CH):0]    active_ch
);

  localparam int c_bytes = DATA_W / 8;
  localparam int c_idx_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
  localparam int c_aw    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int c_pw    = $clog2(DEPTH_WORDS) + 1;
  localparam int c_iw    = (CH > 1) ? $clog2(CH) : 1;
  localparam int c_acw   = $clog2(CH) + 1;

  tx_state_t            r_state, w_state_n;
  logic [CH-1:0]        w_grant_oh, r_grant_oh;
  logic [c_iw-1:0]      w_grant_idx, r_grant, r_rr_ptr;
  logic                 w_any_req;
  logic [c_acw-1:0]     r_active;
  logic [DATA_W-1:0]    w_data, r_rd_data, w_shift;
  logic [c_bytes-1:0]   w_keep;
  logic [KEEP_MAX-1:0]  w_keep_ext;
  logic                 w_valid, w_last, w_full, w_wr_en, w_drop_inc;
  logic [4:0]           w_word_bytes;
  logic [15:0]          r_byte_len, w_len_n, r_tx_cnt, r_frame_cnt, r_drop_cnt;
  logic [c_pw-1:0]      r_wr_ptr;
  logic [c_aw-1:0]      r_rd_word, w_rd_word;
  logic [c_idx_w-1:0]   r_byte_idx;
  logic                 w_pay_fire, w_pay_last, w_word_end;
  logic [31:0]          r_src_ip, r_dst_ip;
  logic [15:0]          r_src_port, r_dest_port;
  logic [DATA_W-1:0]    r_mem [DEPTH_WORDS];

  rr_arbiter #(.CH(CH), .IW(c_iw)) u_arb (
    .i_req   (s_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_any   (w_any_req)
  );

  assign w_data  = s_tdata[int'(r_grant)*DATA_W +: DATA_W];
  assign w_keep  = s_tkeep[int'(r_grant)*c_bytes +: c_bytes];
  assign w_valid = s_tvalid[r_grant];
  assign w_last  = s_tlast[r_grant];
  assign w_full  = (r_wr_ptr == c_pw'(DEPTH_WORDS));

  always_comb begin
    w_keep_ext = '0;
    w_keep_ext[c_bytes-1:0] = w_keep;
  end

  // Only the closing word may be partial; earlier words always carry a full beat.
  assign w_word_bytes = w_last ? keep_popcount(w_keep_ext) : 5'(c_bytes);
  assign w_len_n      = r_byte_len + 16'(w_word_bytes);

  assign w_pay_fire = (r_state == PAYLOAD) && tx_udp_payload_axis_tready;
  assign w_pay_last = (r_tx_cnt == r_byte_len - 16'd1);
  assign w_word_end = (r_byte_idx == c_idx_w'(c_bytes - 1));
  // Prefetch the next word on the last byte of the current one so there are no bubbles.
  assign w_rd_word  = (w_pay_fire && w_word_end) ? r_rd_word + c_aw'(1) : r_rd_word;
  assign w_shift    = r_rd_data << {r_byte_idx, 3'b000};

  always_ff @(posedge sys_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_wr_en    = 1'b0;
    w_drop_inc = 1'b0;
    case (r_state)
      IDLE:    if (w_any_req) w_state_n = COLLECT;
      COLLECT: begin
        if (w_valid) begin
          if (w_full) begin
            if (w_last) begin
              w_drop_inc = 1'b1;
              w_state_n  = IDLE;
            end else begin
              w_state_n  = DROP;
            end
          end else begin
            w_wr_en = 1'b1;
            if (w_last) begin
              if (w_len_n == 16'd0) begin
                w_drop_inc = 1'b1;
                w_state_n  = IDLE;
              end else begin
                w_state_n  = HDR;
              end
            end
          end
        end
      end
      DROP: begin
        if (w_valid && w_last) begin
          w_drop_inc = 1'b1;
          w_state_n  = IDLE;
        end
      end
      HDR:     if (tx_udp_hdr_ready) w_state_n = PAYLOAD;
      PAYLOAD: if (w_pay_fire && w_pay_last) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_rr_ptr    <= c_iw'(CH - 1);
      r_grant     <= '0;
      r_grant_oh  <= '0;
      r_active    <= '1;
      r_wr_ptr    <= '0;
      r_byte_len  <= '0;
      r_rd_word   <= '0;
      r_byte_idx  <= '0;
      r_tx_cnt    <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_src_ip    <= '0;
      r_dst_ip    <= '0;
      r_src_port  <= '0;
      r_dest_port <= '0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_grant     <= w_grant_idx;
        r_grant_oh  <= w_grant_oh;
        r_rr_ptr    <= w_grant_idx;
        r_active    <= c_acw'(w_grant_idx);
        r_dest_port <= dest_ports[int'(w_grant_idx)*16 +: 16];
        r_wr_ptr    <= '0;
        r_byte_len  <= '0;
        r_rd_word   <= '0;
        r_byte_idx  <= '0;
        r_tx_cnt    <= '0;
      end
      if (w_wr_en) begin
        r_wr_ptr   <= r_wr_ptr + c_pw'(1);
        r_byte_len <= w_len_n;
      end
      if (r_state == COLLECT && w_state_n == HDR) begin
        r_src_ip   <= local_ip;
        r_dst_ip   <= dest_ip;
        r_src_port <= local_port;
      end
      if (w_pay_fire) begin
        r_tx_cnt   <= r_tx_cnt + 16'd1;
        r_byte_idx <= w_word_end ? '0 : r_byte_idx + c_idx_w'(1);
        r_rd_word  <= w_rd_word;
      end
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_pay_fire && w_pay_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (r_state != IDLE && w_state_n == IDLE) r_active <= '1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[c_aw-1:0]] <= w_data;
    r_rd_data <= r_mem[w_rd_word];
  end

  assign s_tready                   = (r_state == COLLECT || r_state == DROP) ? r_grant_oh : '0;
  assign tx_udp_hdr_valid           = (r_state == HDR);
  assign tx_udp_ip_dscp             = 6'd0;
  assign tx_udp_ip_ecn              = 2'd0;
  assign tx_udp_ip_ttl              = 8'(TTL);
  assign tx_udp_ip_source_ip        = r_src_ip;
  assign tx_udp_ip_dest_ip          = r_dst_ip;
  assign tx_udp_source_port         = r_src_port;
  assign tx_udp_dest_port           = r_dest_port;
  assign tx_udp_length              = r_byte_len + 16'(UDP_HDR_LEN);
  assign tx_udp_checksum            = 16'd0;
  assign tx_udp_payload_axis_tdata  = w_shift[DATA_W-1 -: 8];
  assign tx_udp_payload_axis_tvalid = (r_state == PAYLOAD);
  assign tx_udp_payload_axis_tlast  = (r_state == PAYLOAD) && w_pay_last;
  assign tx_udp_payload_axis_tuser  = 1'b0;
  assign tx_frame_count             = r_frame_cnt;
  assign drop_count                 = r_drop_cnt;
  assign active_ch                  = r_active;

endmodule
`default_nettype wire
